memory_request_handler: RTL and testbench

Responder side of the control unit's memory request handshake. Accepts instruction-fetch, data-read and data-write requests from `instruction_decoder`, performs byte-wide transactions on the external memory bus, assembles or splits 16-bit double-byte transfers, and returns the single-cycle `memory_acknowledge` pulse together with the fetched opcode or immediate/data word. It sits between the control unit and the Caravel-side memory bus.

---
 rtl/memory_request_handler.sv | 195 +++++++++++++++++++
 tb/tb_memory_request_handler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_request_handler.sv
// Memory request responder: serves fetch, data-read and data-write requests as
// one or two little-endian byte transfers on the external bus, then pulses an ack.
module memory_request_handler #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        next_instr_req,
   input  logic [15:0] pc,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic        dbl_byte_en,
   input  logic [15:0] read_addr,
   input  logic [15:0] write_addr,
   input  logic [15:0] write_data,
   output logic        memory_acknowledge,
   output logic [7:0]  opcode,
   output logic [15:0] imm_o,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_read,
   output logic        bus_write,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ready,
   output logic        bus_error
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, ACK} state_t;
   typedef enum logic [1:0] {KIND_FETCH, KIND_READ, KIND_WRITE} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d;
   logic [15:0]       addr_q, addr_d;
   logic              dbl_q, dbl_d;
   logic [15:0]       data_q, data_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [15:0]       imm_q, imm_d;
   logic [15:0]       bus_addr_q, bus_addr_d;
   logic [7:0]        bus_wdata_q, bus_wdata_d;
   logic              bus_read_q, bus_read_d;
   logic              bus_write_q, bus_write_d;
   logic              err_q, err_d;

   logic              byte_done;
   logic              timed_out;
   logic [7:0]        rbyte;
   logic              strobe;

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      addr_d      = addr_q;
      dbl_d       = dbl_q;
      data_d      = data_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      ack_d       = 1'b0;
      opcode_d    = opcode_q;
      imm_d       = imm_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      err_d       = err_q;
      byte_done   = 1'b0;
      timed_out   = 1'b0;
      rbyte       = bus_rdata;
      strobe      = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_write_en) begin
               kind_d  = KIND_WRITE;
               addr_d  = write_addr;
               dbl_d   = dbl_byte_en;
               data_d  = write_data;
               state_d = BYTE0;
            end else if (mem_read_en) begin
               kind_d  = KIND_READ;
               addr_d  = read_addr;
               dbl_d   = dbl_byte_en;
               state_d = BYTE0;
            end else if (next_instr_req) begin
               kind_d  = KIND_FETCH;
               addr_d  = pc;
               dbl_d   = 1'b0;
               state_d = BYTE0;
            end
            if (state_d == BYTE0) begin
               cnt_d   = '0;
               rdata_d = '0;
            end
         end
         BYTE0, BYTE1: begin
            // An abandoned byte completes like a ready one, with 0xFF as its data.
            timed_out = !bus_ready && (cnt_q == CNT_MAX);
            byte_done = bus_ready || timed_out;
            rbyte     = timed_out ? 8'hFF : bus_rdata;
            if (!byte_done) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               err_d = err_q | timed_out;
               if (state_q == BYTE0) begin
                  rdata_d[7:0] = rbyte;
                  state_d      = dbl_q ? BYTE1 : ACK;
               end else begin
                  rdata_d[15:8] = rbyte;
                  state_d       = ACK;
               end
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Every output is registered, so it is derived from the next state.
      strobe      = (state_d == BYTE0) || (state_d == BYTE1);
      bus_read_d  = strobe && (kind_d != KIND_WRITE);
      bus_write_d = strobe && (kind_d == KIND_WRITE);

      if (state_d == ACK) begin
         ack_d = 1'b1;
         if (kind_q == KIND_FETCH) begin
            opcode_d = rdata_d[7:0];
         end else if (kind_q == KIND_READ) begin
            imm_d = dbl_q ? rdata_d : {8'h00, rdata_d[7:0]};
         end
      end

      if (state_q == IDLE && state_d == BYTE0) begin
         bus_addr_d = addr_d;
         if (kind_d == KIND_WRITE) begin
            bus_wdata_d = data_d[7:0];
         end
      end

      if (state_q == BYTE0 && state_d == BYTE1) begin
         bus_addr_d = addr_q + 16'd1;
         if (kind_q == KIND_WRITE) begin
            bus_wdata_d = data_q[15:8];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         kind_q      <= KIND_FETCH;
         addr_q      <= '0;
         dbl_q       <= 1'b0;
         data_q      <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         opcode_q    <= '0;
         imm_q       <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_read_q  <= 1'b0;
         bus_write_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         dbl_q       <= dbl_d;
         data_q      <= data_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         opcode_q    <= opcode_d;
         imm_q       <= imm_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_read_q  <= bus_read_d;
         bus_write_q <= bus_write_d;
         err_q       <= err_d;
      end
   end

   assign memory_acknowledge = ack_q;
   assign opcode             = opcode_q;
   assign imm_o              = imm_q;
   assign bus_addr           = bus_addr_q;
   assign bus_wdata          = bus_wdata_q;
   assign bus_read           = bus_read_q;
   assign bus_write          = bus_write_q;
   assign bus_error          = err_q;

endmodule

// File: tb/tb_memory_request_handler.sv
// Bench for memory_request_handler: table of single requests, a memory-model bus
// responder with configurable wait states, and an ack-driven scoreboard.
module tb_memory_request_handler;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        next_instr_req = 1'b0;
   logic [15:0] pc = '0;
   logic        mem_read_en = 1'b0;
   logic        mem_write_en = 1'b0;
   logic        dbl_byte_en = 1'b0;
   logic [15:0] read_addr = '0;
   logic [15:0] write_addr = '0;
   logic [15:0] write_data = '0;
   logic        memory_acknowledge;
   logic [7:0]  opcode;
   logic [15:0] imm_o;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_read;
   logic        bus_write;
   logic [7:0]  bus_rdata = '0;
   logic        bus_ready = 1'b0;
   logic        bus_error;

   memory_request_handler #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .nrst(nrst), .next_instr_req(next_instr_req), .pc(pc),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .dbl_byte_en(dbl_byte_en),
      .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
      .memory_acknowledge(memory_acknowledge), .opcode(opcode), .imm_o(imm_o),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_write(bus_write),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Byte-wide memory model answering the strobes after waits_cfg not-ready cycles
   logic [7:0] mem [0:65535];
   int waits_cfg = 0;
   int wcnt = 0;
   typedef struct {logic [15:0] addr; logic [7:0] wdata; logic wr;} blog_t;
   blog_t blog[$];

   always @(negedge clk) begin : responder
      if (bus_read || bus_write) begin
         if (wcnt < waits_cfg) begin
            bus_ready = 1'b0;
            wcnt++;
         end else begin
            bus_ready = 1'b1;
            wcnt = 0;
            bus_rdata = mem[bus_addr];
            if (bus_write) mem[bus_addr] = bus_wdata;
            blog.push_back('{bus_addr, bus_wdata, bus_write});
         end
      end else begin
         bus_ready = 1'b0;
         bus_rdata = 8'h00;
         wcnt = 0;
      end
   end

   typedef struct {logic [7:0] op; logic [15:0] imm; int lmin; int lmax; int rc; logic err;} exp_t;
   exp_t sbq[$];
   logic prev_ack = 1'b0;

   always @(negedge clk) begin : monitor
      exp_t e;
      int lat;
      if (!nrst) begin
         prev_ack = 1'b0;
      end else begin
         if (bus_read || bus_write) chk("strobe_excl", 32'(bus_read & bus_write), 32'd0);
         if (memory_acknowledge) begin
            chk("ack_pulse", 32'(prev_ack), 32'd0);
            chk("ack_strobes_low", 32'({bus_read, bus_write}), 32'd0);
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
               e = sbq.pop_front();
               chk("opcode", 32'(opcode), 32'(e.op));
               chk("imm_o", 32'(imm_o), 32'(e.imm));
               chk("bus_error", 32'(bus_error), 32'(e.err));
               lat = cyc - e.rc;
               n_cmp++;
               if (lat < e.lmin || lat > e.lmax) begin
                  n_bad++;
                  $display("FAIL ack_latency: got %0d, expected %0d..%0d", lat, e.lmin, e.lmax);
               end
            end
         end
         prev_ack = memory_acknowledge;
      end
   end

   task automatic push_exp(input logic [7:0] op, input logic [15:0] imm,
                           input int lmin, input int lmax, input logic err);
      sbq.push_back('{op, imm, lmin, lmax, cyc, err});
   endtask

   task automatic drive(input int kind, input logic [15:0] a, input logic [15:0] wd, input logic dbl);
      dbl_byte_en = dbl;
      case (kind)
         0: begin next_instr_req = 1'b1; pc = a; end
         1: begin mem_read_en = 1'b1; read_addr = a; end
         default: begin mem_write_en = 1'b1; write_addr = a; write_data = wd; end
      endcase
   endtask

   task automatic drop_all();
      next_instr_req = 1'b0;
      mem_read_en = 1'b0;
      mem_write_en = 1'b0;
      dbl_byte_en = 1'b0;
   endtask

   task automatic wait_ack(input string nm, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!memory_acknowledge && n < limit);
      if (!memory_acknowledge) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_ack_timeout: got no ack in %0d cycles, expected an ack", nm, limit);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ack"}, 32'(memory_acknowledge), 32'd0);
      chk({nm, "_bus_read"}, 32'(bus_read), 32'd0);
      chk({nm, "_bus_write"}, 32'(bus_write), 32'd0);
      chk({nm, "_bus_error"}, 32'(bus_error), 32'd0);
      chk({nm, "_opcode"}, 32'(opcode), 32'h00);
      chk({nm, "_imm_o"}, 32'(imm_o), 32'h0000);
      chk({nm, "_bus_addr"}, 32'(bus_addr), 32'h0000);
      chk({nm, "_bus_wdata"}, 32'(bus_wdata), 32'h00);
   endtask

   // kind: 0 fetch, 1 read, 2 write; b0/b1 preset memory at addr/addr+1
   typedef struct {
      int kind; logic [15:0] addr; logic [15:0] wdata; logic dbl;
      logic [7:0] b0; logic [7:0] b1; int waits; int lat; int nbytes;
      logic [7:0] exp_op; logic [15:0] exp_imm;
   } vec_t;
   vec_t vt[9];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected the bench to end");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t v;
      logic [15:0] a1;
      logic [7:0] cur_op;
      logic [15:0] cur_imm;
      int found;

      vt[0] = '{0, 16'h0100, 16'h0000, 1'b0, 8'h3E, 8'h00, 0, 2, 1, 8'h3E, 16'h0000};
      vt[1] = '{1, 16'h2000, 16'h0000, 1'b1, 8'h34, 8'h12, 0, 3, 2, 8'h3E, 16'h1234};
      vt[2] = '{2, 16'hFFFF, 16'hABCD, 1'b1, 8'h00, 8'h00, 0, 3, 2, 8'h3E, 16'h1234};
      vt[3] = '{1, 16'h0040, 16'h0000, 1'b0, 8'h5A, 8'h77, 0, 2, 1, 8'h3E, 16'h005A};
      vt[4] = '{2, 16'h0300, 16'h99C3, 1'b0, 8'h00, 8'h11, 0, 2, 1, 8'h3E, 16'h005A};
      vt[5] = '{1, 16'h0500, 16'h0000, 1'b0, 8'h81, 8'h22, 3, 5, 1, 8'h3E, 16'h0081};
      vt[6] = '{0, 16'h0600, 16'h0000, 1'b1, 8'hA7, 8'h55, 0, 2, 1, 8'hA7, 16'h0081};
      vt[7] = '{1, 16'h1234, 16'h0000, 1'b1, 8'hEF, 8'hBE, 1, 5, 2, 8'hA7, 16'hBEEF};
      vt[8] = '{1, 16'hFFFF, 16'h0000, 1'b1, 8'h01, 8'h80, 0, 3, 2, 8'hA7, 16'h8001};
      cur_op = 8'h00;
      cur_imm = 16'h0000;

      repeat (3) @(negedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         v = vt[i];
         a1 = v.addr + 16'd1;
         mem[v.addr] = v.b0;
         mem[a1] = v.b1;
         waits_cfg = v.waits;
         blog.delete();
         push_exp(v.exp_op, v.exp_imm, v.lat, v.lat, 1'b0);
         drive(v.kind, v.addr, v.wdata, v.dbl);
         wait_ack($sformatf("vec%0d", i), 40);
         drop_all();
         chk($sformatf("vec%0d_nbytes", i), 32'(blog.size()), 32'(v.nbytes));
         for (int j = 0; j < blog.size() && j < v.nbytes; j++) begin
            chk($sformatf("vec%0d_addr%0d", i, j), 32'(blog[j].addr), 32'(j == 0 ? v.addr : a1));
            chk($sformatf("vec%0d_wr%0d", i, j), 32'(blog[j].wr), 32'(v.kind == 2));
            if (v.kind == 2)
               chk($sformatf("vec%0d_wdata%0d", i, j), 32'(blog[j].wdata),
                   32'(j == 0 ? v.wdata[7:0] : v.wdata[15:8]));
         end
         if (v.kind == 2) begin
            chk($sformatf("vec%0d_mem_lo", i), 32'(mem[v.addr]), 32'(v.wdata[7:0]));
            chk($sformatf("vec%0d_mem_hi", i), 32'(mem[a1]), 32'(v.dbl ? v.wdata[15:8] : v.b1));
         end
         cur_op = v.exp_op;
         cur_imm = v.exp_imm;
         repeat (2) @(negedge clk);
      end

      // Simultaneous requests: write first, then read of the written byte, then fetch of it
      mem[16'h0700] = 8'h00;
      waits_cfg = 0;
      push_exp(cur_op, cur_imm, 2, 2, 1'b0);
      push_exp(cur_op, 16'h0042, 5, 5, 1'b0);
      push_exp(8'h42, 16'h0042, 8, 8, 1'b0);
      dbl_byte_en = 1'b0;
      mem_write_en = 1'b1; write_addr = 16'h0700; write_data = 16'h5542;
      mem_read_en = 1'b1; read_addr = 16'h0700;
      next_instr_req = 1'b1; pc = 16'h0700;
      wait_ack("prio_write", 20);
      mem_write_en = 1'b0;
      wait_ack("prio_read", 20);
      mem_read_en = 1'b0;
      wait_ack("prio_fetch", 20);
      next_instr_req = 1'b0;
      cur_op = 8'h42;
      cur_imm = 16'h0042;
      repeat (2) @(negedge clk);

      // Bus never ready: the byte is abandoned as 0xFF and the error flag sticks
      waits_cfg = 1000;
      chk("err_before_timeout", 32'(bus_error), 32'd0);
      push_exp(cur_op, 16'h00FF, TMO + 1, TMO + 2, 1'b1);
      drive(1, 16'h0800, 16'h0000, 1'b0);
      wait_ack("timeout", 40);
      drop_all();
      waits_cfg = 0;
      repeat (3) @(negedge clk);
      chk("err_sticky_idle", 32'(bus_error), 32'd1);
      mem[16'h0801] = 8'h5C;
      push_exp(8'h5C, 16'h00FF, 2, 2, 1'b1);
      drive(0, 16'h0801, 16'h0000, 1'b0);
      wait_ack("after_timeout", 20);
      drop_all();
      cur_op = 8'h5C;
      repeat (2) @(negedge clk);

      // Reset in the middle of the second byte of a double read
      waits_cfg = 2;
      mem[16'h0900] = 8'h11;
      mem[16'h0901] = 8'h22;
      drive(1, 16'h0900, 16'h0000, 1'b1);
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         @(negedge clk);
         if (bus_read && bus_addr == 16'h0901) found = 1;
      end
      chk("byte1_reached", 32'(found), 32'd1);
      nrst = 1'b0;
      #1 chk_reset_vals("midreset");
      drop_all();
      repeat (2) @(negedge clk);
      chk("midreset_no_ack", 32'(memory_acknowledge), 32'd0);
      nrst = 1'b1;
      waits_cfg = 0;
      @(negedge clk);
      mem[16'h0A00] = 8'h6D;
      blog.delete();
      push_exp(8'h6D, 16'h0000, 2, 2, 1'b0);
      drive(0, 16'h0A00, 16'h0000, 1'b0);
      wait_ack("post_reset", 20);
      drop_all();
      chk("post_reset_addr", 32'(blog.size() > 0 ? blog[0].addr : 16'hDEAD), 32'h0A00);
      repeat (3) @(negedge clk);

      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
